// File: rtl/parking_gate_controller.sv
// Parking gate front-end: sensor conditioning, card sync and one barrier FSM per lane.
// Each lane admits at most one vehicle per debounced rising edge of its loop sensor.

// 2-FF synchronizer followed by a counting debouncer for one vehicle loop sensor.
module pgc_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise_c
);

   logic             sync_1;
   logic             sync_2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // Synchronize, then flip the level after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= raw;
         sync_2  <= sync_1;
         level_d <= level;
         if (sync_2 != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync_2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise_c = level & ~level_d;

endmodule

module parking_gate_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned BARRIER_CYCLES  = 8,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic entry_sensor,
   input  logic entry_uni_card,
   input  logic exit_sensor,
   input  logic exit_uni_card,
   input  logic uni_space_ok,
   input  logic space_ok,
   output logic car_entered,
   output logic is_uni_car_entered,
   output logic car_exited,
   output logic is_uni_car_exited,
   output logic entry_barrier_open,
   output logic exit_barrier_open,
   output logic entry_denied
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      OPEN   = 3'd2,
      CLOSE  = 3'd3,
      DENIED = 3'd4
   } lane_state_e;

   localparam int unsigned BAR_LAST = BARRIER_CYCLES - 1;

   logic en_level;
   logic en_rise_c;
   logic ex_level;
   logic ex_rise_c;

   logic en_card_s1;
   logic en_card_s2;
   logic ex_card_s1;
   logic ex_card_s2;

   lane_state_e      en_state;
   lane_state_e      en_state_nxt;
   logic [CNT_W-1:0] en_bcnt;
   logic [CNT_W-1:0] en_bcnt_nxt;
   logic             en_uni;
   logic             en_uni_nxt;
   logic             en_admit_c;
   logic             entry_barrier_open_nxt;
   logic             car_entered_nxt;
   logic             is_uni_car_entered_nxt;
   logic             entry_denied_nxt;

   lane_state_e      ex_state;
   lane_state_e      ex_state_nxt;
   logic [CNT_W-1:0] ex_bcnt;
   logic [CNT_W-1:0] ex_bcnt_nxt;
   logic             ex_uni;
   logic             ex_uni_nxt;
   logic             exit_barrier_open_nxt;
   logic             car_exited_nxt;
   logic             is_uni_car_exited_nxt;

   pgc_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_entry_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (entry_sensor),
      .level  (en_level),
      .rise_c (en_rise_c)
   );

   pgc_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_exit_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (exit_sensor),
      .level  (ex_level),
      .rise_c (ex_rise_c)
   );

   // Card readers are level signals; synchronize only, no debounce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_card_s1 <= 1'b0;
         en_card_s2 <= 1'b0;
         ex_card_s1 <= 1'b0;
         ex_card_s2 <= 1'b0;
      end else begin
         en_card_s1 <= entry_uni_card;
         en_card_s2 <= en_card_s1;
         ex_card_s1 <= exit_uni_card;
         ex_card_s2 <= ex_card_s1;
      end
   end

   // Space availability is only consulted while the entry lane is in CHECK.
   assign en_admit_c = en_uni ? uni_space_ok : space_ok;

   // Entry lane: state, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_state           <= IDLE;
         en_bcnt            <= '0;
         en_uni             <= 1'b0;
         entry_barrier_open <= 1'b0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         entry_denied       <= 1'b0;
      end else begin
         en_state           <= en_state_nxt;
         en_bcnt            <= en_bcnt_nxt;
         en_uni             <= en_uni_nxt;
         entry_barrier_open <= entry_barrier_open_nxt;
         car_entered        <= car_entered_nxt;
         is_uni_car_entered <= is_uni_car_entered_nxt;
         entry_denied       <= entry_denied_nxt;
      end
   end

   // Entry lane next-state logic.
   always_comb begin
      en_state_nxt = en_state;
      en_bcnt_nxt  = en_bcnt;
      en_uni_nxt   = en_uni;
      case (en_state)
         IDLE: begin
            if (en_rise_c) begin
               en_uni_nxt   = en_card_s2;
               en_state_nxt = CHECK;
            end
         end
         CHECK: begin
            en_state_nxt = en_admit_c ? OPEN : DENIED;
         end
         OPEN: begin
            if (!en_level) begin
               en_state_nxt = CLOSE;
               en_bcnt_nxt  = '0;
            end
         end
         CLOSE: begin
            if (en_bcnt == CNT_W'(BAR_LAST)) begin
               en_state_nxt = IDLE;
            end else begin
               en_bcnt_nxt = en_bcnt + CNT_W'(1);
            end
         end
         DENIED: begin
            if (!en_level) begin
               en_state_nxt = IDLE;
            end
         end
         default: begin
            en_state_nxt = IDLE;
         end
      endcase
   end

   // Entry lane output values for the next cycle.
   always_comb begin
      entry_barrier_open_nxt = (en_state_nxt == OPEN);
      car_entered_nxt        = (en_state == OPEN) && !en_level;
      entry_denied_nxt       = (en_state == CHECK) && !en_admit_c;
      is_uni_car_entered_nxt = car_entered_nxt ? en_uni : is_uni_car_entered;
   end

   // Exit lane: state, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_state          <= IDLE;
         ex_bcnt           <= '0;
         ex_uni            <= 1'b0;
         exit_barrier_open <= 1'b0;
         car_exited        <= 1'b0;
         is_uni_car_exited <= 1'b0;
      end else begin
         ex_state          <= ex_state_nxt;
         ex_bcnt           <= ex_bcnt_nxt;
         ex_uni            <= ex_uni_nxt;
         exit_barrier_open <= exit_barrier_open_nxt;
         car_exited        <= car_exited_nxt;
         is_uni_car_exited <= is_uni_car_exited_nxt;
      end
   end

   // Exit lane next-state logic; leaving is never refused.
   always_comb begin
      ex_state_nxt = ex_state;
      ex_bcnt_nxt  = ex_bcnt;
      ex_uni_nxt   = ex_uni;
      case (ex_state)
         IDLE: begin
            if (ex_rise_c) begin
               ex_uni_nxt   = ex_card_s2;
               ex_state_nxt = CHECK;
            end
         end
         CHECK: begin
            ex_state_nxt = OPEN;
         end
         OPEN: begin
            if (!ex_level) begin
               ex_state_nxt = CLOSE;
               ex_bcnt_nxt  = '0;
            end
         end
         CLOSE: begin
            if (ex_bcnt == CNT_W'(BAR_LAST)) begin
               ex_state_nxt = IDLE;
            end else begin
               ex_bcnt_nxt = ex_bcnt + CNT_W'(1);
            end
         end
         default: begin
            ex_state_nxt = IDLE;
         end
      endcase
   end

   // Exit lane output values for the next cycle.
   always_comb begin
      exit_barrier_open_nxt = (ex_state_nxt == OPEN);
      car_exited_nxt        = (ex_state == OPEN) && !ex_level;
      is_uni_car_exited_nxt = car_exited_nxt ? ex_uni : is_uni_car_exited;
   end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller (DEBOUNCE_CYCLES=4, BARRIER_CYCLES=8).
// Stimulus pushes expected events with their cycle stamps; the monitor pops on each DUT output event.
`timescale 1ns/1ps
module tb_parking_gate_controller;

   localparam int unsigned RISE_LAT = 8;   // raw rise -> barrier open
   localparam int unsigned FALL_LAT = 7;   // raw fall -> event pulse

   typedef struct {
      int unsigned cyc;
      logic        uni;
   } exp_t;

   typedef struct {
      int unsigned cyc;
      int          sig;
      logic        val;
   } lvl_t;

   logic clk = 1'b0;
   logic rst;
   logic entry_sensor;
   logic entry_uni_card;
   logic exit_sensor;
   logic exit_uni_card;
   logic uni_space_ok;
   logic space_ok;
   logic car_entered;
   logic is_uni_car_entered;
   logic car_exited;
   logic is_uni_car_exited;
   logic entry_barrier_open;
   logic exit_barrier_open;
   logic entry_denied;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic        done = 1'b0;

   exp_t q_ent[$];
   exp_t q_ext[$];
   exp_t q_den[$];
   exp_t q_ebar[$];
   exp_t q_xbar[$];
   lvl_t q_lvl[$];

   exp_t e;
   lvl_t l;
   logic prev_ebar = 1'b0;
   logic prev_xbar = 1'b0;
   logic prev_uni_en = 1'b0;
   logic prev_uni_ex = 1'b0;
   logic act;

   parking_gate_controller #(
      .DEBOUNCE_CYCLES (4),
      .BARRIER_CYCLES  (8),
      .CNT_W           (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .entry_sensor       (entry_sensor),
      .entry_uni_card     (entry_uni_card),
      .exit_sensor        (exit_sensor),
      .exit_uni_card      (exit_uni_card),
      .uni_space_ok       (uni_space_ok),
      .space_ok           (space_ok),
      .car_entered        (car_entered),
      .is_uni_car_entered (is_uni_car_entered),
      .car_exited         (car_exited),
      .is_uni_car_exited  (is_uni_car_exited),
      .entry_barrier_open (entry_barrier_open),
      .exit_barrier_open  (exit_barrier_open),
      .entry_denied       (entry_denied)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic sig_val(input int id);
      case (id)
         0: return entry_barrier_open;
         1: return exit_barrier_open;
         2: return car_entered;
         3: return car_exited;
         4: return entry_denied;
         5: return is_uni_car_entered;
         default: return is_uni_car_exited;
      endcase
   endfunction

   function automatic string sig_name(input int id);
      case (id)
         0: return "entry_barrier_open";
         1: return "exit_barrier_open";
         2: return "car_entered";
         3: return "car_exited";
         4: return "entry_denied";
         5: return "is_uni_car_entered";
         default: return "is_uni_car_exited";
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_lvl(input int unsigned at, input int id, input logic v);
      q_lvl.push_back('{cyc: at, sig: id, val: v});
   endtask

   // Monitor: sole owner of the comparison counters.
   always @(negedge clk) begin
      if (car_entered) begin
         n_cmp++;
         if (q_ent.size() == 0) begin
            n_fail++;
            $display("FAIL car_entered: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            e = q_ent.pop_front();
            if (cyc != e.cyc || is_uni_car_entered !== e.uni || entry_barrier_open !== 1'b0) begin
               n_fail++;
               $display("FAIL car_entered: cycle %0d uni %b barrier %b, required cycle %0d uni %b barrier 0",
                        cyc, is_uni_car_entered, entry_barrier_open, e.cyc, e.uni);
            end
         end
      end
      if (car_exited) begin
         n_cmp++;
         if (q_ext.size() == 0) begin
            n_fail++;
            $display("FAIL car_exited: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            e = q_ext.pop_front();
            if (cyc != e.cyc || is_uni_car_exited !== e.uni || exit_barrier_open !== 1'b0) begin
               n_fail++;
               $display("FAIL car_exited: cycle %0d uni %b barrier %b, required cycle %0d uni %b barrier 0",
                        cyc, is_uni_car_exited, exit_barrier_open, e.cyc, e.uni);
            end
         end
      end
      if (entry_denied) begin
         n_cmp++;
         if (q_den.size() == 0) begin
            n_fail++;
            $display("FAIL entry_denied: unexpected pulse at cycle %0d, required none", cyc);
         end else begin
            e = q_den.pop_front();
            if (cyc != e.cyc || entry_barrier_open !== 1'b0) begin
               n_fail++;
               $display("FAIL entry_denied: cycle %0d barrier %b, required cycle %0d barrier 0",
                        cyc, entry_barrier_open, e.cyc);
            end
         end
      end
      if (entry_barrier_open && !prev_ebar) begin
         n_cmp++;
         if (q_ebar.size() == 0) begin
            n_fail++;
            $display("FAIL entry_open: unexpected rise at cycle %0d, required none", cyc);
         end else begin
            e = q_ebar.pop_front();
            if (cyc != e.cyc) begin
               n_fail++;
               $display("FAIL entry_open: rise at cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
      end
      if (exit_barrier_open && !prev_xbar) begin
         n_cmp++;
         if (q_xbar.size() == 0) begin
            n_fail++;
            $display("FAIL exit_open: unexpected rise at cycle %0d, required none", cyc);
         end else begin
            e = q_xbar.pop_front();
            if (cyc != e.cyc) begin
               n_fail++;
               $display("FAIL exit_open: rise at cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
      end
      if (!rst && !car_entered && is_uni_car_entered !== prev_uni_en) begin
         n_cmp++;
         n_fail++;
         $display("FAIL uni_entered_hold: changed to %b at cycle %0d without an event, required %b",
                  is_uni_car_entered, cyc, prev_uni_en);
      end
      if (!rst && !car_exited && is_uni_car_exited !== prev_uni_ex) begin
         n_cmp++;
         n_fail++;
         $display("FAIL uni_exited_hold: changed to %b at cycle %0d without an event, required %b",
                  is_uni_car_exited, cyc, prev_uni_ex);
      end
      while (q_lvl.size() != 0 && q_lvl[0].cyc <= cyc) begin
         l = q_lvl.pop_front();
         act = sig_val(l.sig);
         n_cmp++;
         if (act !== l.val) begin
            n_fail++;
            $display("FAIL level %s: got %b at cycle %0d, required %b", sig_name(l.sig), act, cyc, l.val);
         end
      end
      prev_ebar   = entry_barrier_open;
      prev_xbar   = exit_barrier_open;
      prev_uni_en = is_uni_car_entered;
      prev_uni_ex = is_uni_car_exited;
      if (done) begin
         if (q_ent.size() + q_ext.size() + q_den.size() + q_ebar.size() + q_xbar.size() + q_lvl.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pending: %0d ent %0d ext %0d den %0d ebar %0d xbar %0d lvl outstanding, required 0",
                     q_ent.size(), q_ext.size(), q_den.size(), q_ebar.size(), q_xbar.size(), q_lvl.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
         $finish;
      end
   end

   initial begin
      rst            = 1'b1;
      entry_sensor   = 1'b0;
      entry_uni_card = 1'b0;
      exit_sensor    = 1'b0;
      exit_uni_card  = 1'b0;
      uni_space_ok   = 1'b1;
      space_ok       = 1'b1;

      // Reset state.
      tick(1);
      for (int i = 0; i < 7; i++) expect_lvl(cyc + 1, i, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(3);

      // Uni car admitted through uni space, sensor held 20 cycles.
      entry_uni_card = 1'b1;
      uni_space_ok   = 1'b1;
      entry_sensor   = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      expect_lvl(cyc + RISE_LAT - 1, 0, 1'b0);
      tick(20);
      entry_sensor = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b1});
      expect_lvl(cyc + FALL_LAT - 1, 0, 1'b1);
      tick(25);

      // 3-cycle glitch must not propagate.
      entry_sensor = 1'b1;
      tick(3);
      entry_sensor = 1'b0;
      expect_lvl(cyc + 10, 0, 1'b0);
      tick(15);

      // Non-uni arrival with no general space: denied, barrier stays closed.
      entry_uni_card = 1'b0;
      space_ok       = 1'b0;
      uni_space_ok   = 1'b0;
      entry_sensor   = 1'b1;
      q_den.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      expect_lvl(cyc + 12, 0, 1'b0);
      tick(15);
      entry_sensor = 1'b0;
      tick(15);

      // Uni arrival with uni space while general space is still full: admitted.
      entry_uni_card = 1'b1;
      uni_space_ok   = 1'b1;
      entry_sensor   = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(15);
      entry_sensor = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b1});
      tick(25);

      // Both lanes with identical timing: same-cycle events, independent uni flags.
      space_ok       = 1'b1;
      entry_uni_card = 1'b1;
      exit_uni_card  = 1'b0;
      entry_sensor   = 1'b1;
      exit_sensor    = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      q_xbar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(12);
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b1});
      q_ext.push_back('{cyc: cyc + FALL_LAT, uni: 1'b0});
      tick(25);

      // Second vehicle debounced during CLOSE is ignored; needs a fresh rise.
      entry_uni_card = 1'b0;
      entry_sensor   = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(10);
      entry_sensor = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b0});
      tick(7);
      entry_sensor = 1'b1;
      expect_lvl(cyc + 15, 0, 1'b0);
      tick(20);
      entry_sensor = 1'b0;
      tick(15);
      entry_sensor = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(10);
      entry_sensor = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b0});
      tick(25);

      // Reset while the entry barrier is open; sensor still high afterwards.
      entry_uni_card = 1'b1;
      uni_space_ok   = 1'b1;
      entry_sensor   = 1'b1;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      expect_lvl(cyc + 10, 0, 1'b1);
      tick(12);
      rst = 1'b1;
      expect_lvl(cyc + 1, 0, 1'b0);
      expect_lvl(cyc + 1, 2, 1'b0);
      expect_lvl(cyc + 1, 5, 1'b0);
      tick(2);
      rst = 1'b0;
      q_ebar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(12);
      entry_sensor = 1'b0;
      q_ent.push_back('{cyc: cyc + FALL_LAT, uni: 1'b1});
      tick(25);

      // Exit is never refused, even with no space flags; uni exit flag set.
      space_ok      = 1'b0;
      uni_space_ok  = 1'b0;
      exit_uni_card = 1'b1;
      exit_sensor   = 1'b1;
      q_xbar.push_back('{cyc: cyc + RISE_LAT, uni: 1'b0});
      tick(12);
      exit_sensor = 1'b0;
      q_ext.push_back('{cyc: cyc + FALL_LAT, uni: 1'b1});
      expect_lvl(cyc + FALL_LAT + 3, 6, 1'b1);
      tick(25);

      done = 1'b1;
      tick(3);
      $display("FAIL monitor: summary not reached within 3 cycles of completion");
      $fatal(1);
   end

endmodule
